// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between the time counters and the 7-segment driver.
// The master drives the binary value in; the slave returns the latched BCD result.
interface bin2bcd_seq_if #(
  parameter int unsigned IN_W   = 7,
  parameter int unsigned DIGITS = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_bin;
  logic                  out_valid;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_ovf;
  logic [DIGITS-1:0]     out_blank;

  modport master (
    output in_valid, in_bin,
    input  in_ready, out_valid, out_bcd, out_ovf, out_blank
  );

  modport slave (
    input  in_valid, in_bin,
    output in_ready, out_valid, out_bcd, out_ovf, out_blank
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with overflow saturation and per-digit leading-zero blanking.
module bin2bcd_seq #(
  parameter int unsigned IN_W   = 7,
  parameter int unsigned DIGITS = 2
) (
  input  logic         clk,
  input  logic         rst,
  bin2bcd_seq_if.slave bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [BCD_W-1:0]  ALL_NINES = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  logic [0:0]        state, state_nxt;
  logic [IN_W-1:0]   sr, sr_nxt;
  logic [BCD_W-1:0]  acc, acc_nxt;
  logic              sticky, sticky_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic              out_valid_q, out_valid_nxt;
  logic [BCD_W-1:0]  out_bcd_q, out_bcd_nxt;
  logic              out_ovf_q, out_ovf_nxt;
  logic [DIGITS-1:0] out_blank_q, out_blank_nxt;

  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  sh_acc;
  logic [IN_W-1:0]   sh_sr;
  logic              sh_out;
  logic              ovf_fin;

  // Bit i set when digit i and every digit above it are zero; digit 0 always shown.
  function automatic logic [DIGITS-1:0] blank_of(input logic [BCD_W-1:0] bcd);
    logic              nz;
    logic [DIGITS-1:0] b;
    nz = 1'b0;
    b  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz   = nz | (bcd[4*i +: 4] != 4'd0);
      b[i] = ~nz;
    end
    b[0] = 1'b0;
    return b;
  endfunction

  // Add-3 on each digit >= 5; the result never exceeds 4'hC so no inter-digit carry.
  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  assign sh_out  = adj[BCD_W-1];
  assign sh_acc  = {adj[BCD_W-2:0], sr[IN_W-1]};
  assign sh_sr   = sr << 1;
  assign ovf_fin = sticky | sh_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sr          <= '0;
      acc         <= '0;
      sticky      <= 1'b0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_blank_q <= BLANK_RST;
    end else begin
      state       <= state_nxt;
      sr          <= sr_nxt;
      acc         <= acc_nxt;
      sticky      <= sticky_nxt;
      cnt         <= cnt_nxt;
      out_valid_q <= out_valid_nxt;
      out_bcd_q   <= out_bcd_nxt;
      out_ovf_q   <= out_ovf_nxt;
      out_blank_q <= out_blank_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sr_nxt        = sr;
    acc_nxt       = acc;
    sticky_nxt    = sticky;
    cnt_nxt       = cnt;
    out_valid_nxt = 1'b0;
    out_bcd_nxt   = out_bcd_q;
    out_ovf_nxt   = out_ovf_q;
    out_blank_nxt = out_blank_q;

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          sr_nxt     = bus.in_bin;
          acc_nxt    = '0;
          sticky_nxt = 1'b0;
          cnt_nxt    = CNT_W'(IN_W);
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        sr_nxt     = sh_sr;
        acc_nxt    = sh_acc;
        sticky_nxt = ovf_fin;
        cnt_nxt    = cnt - CNT_W'(1);
        // Final bit: latch the post-shift result, saturating on overflow.
        if (cnt == CNT_W'(1)) begin
          state_nxt     = IDLE;
          out_valid_nxt = 1'b1;
          out_ovf_nxt   = ovf_fin;
          out_bcd_nxt   = ovf_fin ? ALL_NINES : sh_acc;
          out_blank_nxt = blank_of(out_bcd_nxt);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bcd   = out_bcd_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_blank = out_blank_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: default 7-bit/2-digit instance plus a
// 10-bit/3-digit instance swept against a divide/modulo reference.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bin2bcd_seq_if #(.IN_W(7),  .DIGITS(2)) b7 ();
  bin2bcd_seq_if #(.IN_W(10), .DIGITS(3)) b10 ();

  bin2bcd_seq #(.IN_W(7),  .DIGITS(2)) dut7  (.clk(clk), .rst(rst), .bus(b7));
  bin2bcd_seq #(.IN_W(10), .DIGITS(3)) dut10 (.clk(clk), .rst(rst), .bus(b10));

  typedef struct {
    logic [6:0] bin;
    logic [7:0] bcd;
    logic       ovf;
    logic [1:0] blank;
  } vec7_t;

  typedef struct {
    logic [9:0]  bin;
    logic [11:0] bcd;
    logic        ovf;
    logic [2:0]  blank;
  } vec10_t;

  vec7_t  vt7[8];
  vec10_t vt10[7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the result pulse.
  task automatic run7(input logic [6:0] v, output logic [7:0] bcd, output logic ovf,
                      output logic [1:0] blank, output int lat);
    b7.in_valid = 1'b1;
    b7.in_bin   = v;
    @(negedge clk);
    b7.in_valid = 1'b0;
    b7.in_bin   = ~v;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (b7.out_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    bcd   = b7.out_bcd;
    ovf   = b7.out_ovf;
    blank = b7.out_blank;
    @(negedge clk);
    chk("pulse7", 32'(b7.out_valid), 32'd0);
  endtask

  task automatic run10(input logic [9:0] v, output logic [11:0] bcd, output logic ovf,
                       output logic [2:0] blank, output int lat);
    b10.in_valid = 1'b1;
    b10.in_bin   = v;
    @(negedge clk);
    b10.in_valid = 1'b0;
    b10.in_bin   = ~v;
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      if (b10.out_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    bcd   = b10.out_bcd;
    ovf   = b10.out_ovf;
    blank = b10.out_blank;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]  bcd7;
    logic [1:0]  blank7;
    logic [11:0] bcd10, ebcd;
    logic [2:0]  blank10, eblank;
    logic        ovf, eovf;
    int          lat;
    logic [6:0]  bb_val[3];
    logic [7:0]  bb_exp[3];

    vt7[0] = '{7'd59,  8'h59, 1'b0, 2'b00};
    vt7[1] = '{7'd0,   8'h00, 1'b0, 2'b10};
    vt7[2] = '{7'd7,   8'h07, 1'b0, 2'b10};
    vt7[3] = '{7'd100, 8'h99, 1'b1, 2'b00};
    vt7[4] = '{7'd127, 8'h99, 1'b1, 2'b00};
    vt7[5] = '{7'd99,  8'h99, 1'b0, 2'b00};
    vt7[6] = '{7'd10,  8'h10, 1'b0, 2'b00};
    vt7[7] = '{7'd1,   8'h01, 1'b0, 2'b10};

    vt10[0] = '{10'd305,  12'h305, 1'b0, 3'b000};
    vt10[1] = '{10'd5,    12'h005, 1'b0, 3'b110};
    vt10[2] = '{10'd999,  12'h999, 1'b0, 3'b000};
    vt10[3] = '{10'd1000, 12'h999, 1'b1, 3'b000};
    vt10[4] = '{10'd1023, 12'h999, 1'b1, 3'b000};
    vt10[5] = '{10'd0,    12'h000, 1'b0, 3'b110};
    vt10[6] = '{10'd40,   12'h040, 1'b0, 3'b100};

    b7.in_valid  = 1'b1;
    b7.in_bin    = 7'd42;
    b10.in_valid = 1'b0;
    b10.in_bin   = '0;

    // Reset with in_valid high: reset wins, outputs at reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",   32'(b7.in_ready),  32'd0);
    chk("rst_valid",   32'(b7.out_valid), 32'd0);
    chk("rst_bcd",     32'(b7.out_bcd),   32'h0);
    chk("rst_ovf",     32'(b7.out_ovf),   32'd0);
    chk("rst_blank",   32'(b7.out_blank), 32'b10);
    chk("rst_blank10", 32'(b10.out_blank), 32'b110);
    rst         = 1'b0;
    b7.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(b7.in_ready),  32'd1);
    chk("post_rst_valid", 32'(b7.out_valid), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run7(vt7[i].bin, bcd7, ovf, blank7, lat);
      chk($sformatf("lat7[%0d]", vt7[i].bin),   32'(lat),    32'd7);
      chk($sformatf("bcd7[%0d]", vt7[i].bin),   32'(bcd7),   32'(vt7[i].bcd));
      chk($sformatf("ovf7[%0d]", vt7[i].bin),   32'(ovf),    32'(vt7[i].ovf));
      chk($sformatf("blank7[%0d]", vt7[i].bin), 32'(blank7), 32'(vt7[i].blank));
    end

    // Back-to-back with in_valid held high; in_bin scrambled during SHIFT.
    bb_val[0] = 7'd12; bb_val[1] = 7'd34; bb_val[2] = 7'd56;
    bb_exp[0] = 8'h12; bb_exp[1] = 8'h34; bb_exp[2] = 8'h56;
    b7.in_valid = 1'b1;
    b7.in_bin   = bb_val[0];
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bb_accept_ready[%0d]", k), 32'(b7.in_ready), 32'd1);
      for (int j = 1; j <= 7; j++) begin
        @(negedge clk);
        b7.in_bin = 7'd99 - 7'(j);
        chk($sformatf("bb_busy[%0d.%0d]", k, j), 32'({b7.in_ready, b7.out_valid}), 32'd0);
      end
      @(negedge clk);
      chk($sformatf("bb_valid[%0d]", k), 32'(b7.out_valid), 32'd1);
      chk($sformatf("bb_bcd[%0d]", k),   32'(b7.out_bcd),   32'(bb_exp[k]));
      chk($sformatf("bb_ovf[%0d]", k),   32'(b7.out_ovf),   32'd0);
      if (k < 2) b7.in_bin = bb_val[k+1];
      else       b7.in_valid = 1'b0;
    end
    @(negedge clk);
    chk("bb_idle_ready", 32'(b7.in_ready), 32'd1);

    // Reset three cycles into a conversion of 45 aborts it.
    b7.in_valid = 1'b1;
    b7.in_bin   = 7'd45;
    @(negedge clk);
    b7.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(b7.in_ready),  32'd0);
    chk("abort_valid", 32'(b7.out_valid), 32'd0);
    chk("abort_bcd",   32'(b7.out_bcd),   32'h0);
    chk("abort_ovf",   32'(b7.out_ovf),   32'd0);
    chk("abort_blank", 32'(b7.out_blank), 32'b10);
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk($sformatf("abort_no_valid[%0d]", j), 32'(b7.out_valid), 32'd0);
    end
    chk("abort_ready_after", 32'(b7.in_ready), 32'd1);
    run7(7'd23, bcd7, ovf, blank7, lat);
    chk("abort_next_lat", 32'(lat),  32'd7);
    chk("abort_next_bcd", 32'(bcd7), 32'h23);

    // Wide instance: hand-computed vectors first.
    for (int i = 0; i < 7; i++) begin
      run10(vt10[i].bin, bcd10, ovf, blank10, lat);
      chk($sformatf("lat10[%0d]", vt10[i].bin),   32'(lat),     32'd10);
      chk($sformatf("bcd10[%0d]", vt10[i].bin),   32'(bcd10),   32'(vt10[i].bcd));
      chk($sformatf("ovf10[%0d]", vt10[i].bin),   32'(ovf),     32'(vt10[i].ovf));
      chk($sformatf("blank10[%0d]", vt10[i].bin), 32'(blank10), 32'(vt10[i].blank));
    end

    // Full sweep against a divide/modulo reference.
    for (int v = 0; v < 1024; v++) begin
      if (v >= 1000) begin
        ebcd = 12'h999;
        eovf = 1'b1;
      end else begin
        ebcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        eovf = 1'b0;
      end
      eblank[2] = (ebcd[11:8] == 4'd0);
      eblank[1] = eblank[2] && (ebcd[7:4] == 4'd0);
      eblank[0] = 1'b0;
      run10(10'(v), bcd10, ovf, blank10, lat);
      chk($sformatf("sweep_lat[%0d]", v),   32'(lat),     32'd10);
      chk($sformatf("sweep_bcd[%0d]", v),   32'(bcd10),   32'(ebcd));
      chk($sformatf("sweep_ovf[%0d]", v),   32'(ovf),     32'(eovf));
      chk($sformatf("sweep_blank[%0d]", v), 32'(blank10), 32'(eblank));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised, sequential binary-to-BCD converter for the stopwatch display path. It replaces per-field divide/modulo digit splitting with an iterative shift-and-add-3 (double-dabble) engine that processes one input bit per clock. A valid/ready handshake sits between the time counters and the 7-segment driver. The block adds features the old splitter lacked:

- arbitrary input width and digit count;
- overflow saturation with a flag;
- per-digit leading-zero blanking.

## Interface

Parameters:
- IN_W, default 7: binary input width; must be ≥ 1.
- DIGITS, default 2: number of BCD output digits; must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_bin holds a value to convert.
- in_ready  out  1  block can accept a value; high only in IDLE and not in reset.
- in_bin  in  IN_W  unsigned binary value.
- out_valid  out  1  one-cycle pulse: out_bcd, out_ovf and out_blank just updated.
- out_bcd  out  4*DIGITS  result; digit i in bits [4i+3:4i], digit 0 least significant.
- out_ovf  out  1  input exceeded 10^DIGITS − 1; held with out_bcd.
- out_blank  out  DIGITS  bit i = 1 when digit i and all higher digits are 0; bit 0 is always 0.

## Operation

- State machine with two states:
  - IDLE: in_ready = 1. When in_valid & in_ready at an edge:
    - load in_bin into the shift register;
    - clear the BCD accumulator (DIGITS × 4 bits) and the sticky overflow bit;
    - load bit counter = IN_W;
    - go to SHIFT.
  - SHIFT: in_ready = 0; in_valid is ignored. Each edge:
    - for every accumulator digit, if digit ≥ 5, add 3 (4-bit result);
    - shift the {accumulator, shift register} concatenation left by 1, so the shift-register MSB enters digit 0 LSB;
    - OR the bit shifted out of the top digit into the sticky overflow bit;
    - decrement the counter.
    - On the edge where the counter goes 1→0, go to IDLE and latch the outputs from the post-shift values.
- Output latch:
  - out_ovf = sticky bit, including a bit shifted out on the final edge.
  - out_bcd = all digits 4'h9 if out_ovf, else the accumulator.
  - out_blank is computed from the latched out_bcd.
  - out_valid = 1 for exactly one cycle.
- Outputs hold their last values until the next latch; out_valid is 0 at all other times.
- Digits are always 0–9. The add-3 step never carries between digits.
- The in_bin value is sampled only at the accept edge; later changes have no effect.

## Timing

- Reset values while rst is high and the cycle after:
  - state IDLE;
  - out_valid 0, out_bcd 0, out_ovf 0;
  - out_blank = all ones except bit 0;
  - in_ready 0 while rst is high, 1 in the first cycle after rst falls.
- Latency: a value accepted at edge E0 yields out_valid high in the cycle after edge E0+IN_W. That is IN_W cycles from accept to result.
- Back-to-back: in_ready is high in the same cycle out_valid is high, so a new value can be accepted then. Maximum throughput is one conversion per IN_W+1 cycles.
- Reset mid-conversion aborts the operation: no out_valid is produced, and outputs return to their reset values.
- If rst and in_valid are both high, reset wins and the value is not accepted.
- For IN_W = 1, conversion takes a single SHIFT edge.

## Test plan

- Default params, in_bin = 59, single accept: out_valid exactly 7 cycles after the accept edge; out_bcd = 8'h59, out_ovf = 0, out_blank = 2'b00.
- in_bin = 0, then in_bin = 7: first result out_bcd = 8'h00, out_blank = 2'b10; second result 8'h07, blank 2'b10.
- in_bin = 100 and in_bin = 127: out_bcd = 8'h99 and out_ovf = 1 for both. in_bin = 99: 8'h99 with out_ovf = 0.
- in_valid held high continuously with values 12, 34, 56: accepts every 8 cycles; in_ready low for 7 cycles between accepts; results 8'h12, 8'h34, 8'h56 in order; in_bin changes during SHIFT are ignored.
- Reset asserted 3 cycles into a conversion of 45:
  - no out_valid;
  - outputs at reset values;
  - next accept of 23 gives 8'h23 after 7 cycles.
- IN_W = 10, DIGITS = 3, all inputs 0–1023 against a reference model:
  - 0–999 give the exact BCD with ovf = 0;
  - 1000–1023 give 12'h999 with ovf = 1;
  - e.g. 305 gives 12'h305 with blank 3'b000; 5 gives blank 3'b110.
